// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder/subtractor that reuses a single 2-bit
// full-adder slice once per clock, LSB pair first. A WIDTH-bit operation
// takes WIDTH/2 RUN cycles. The result becomes visible only on completion.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf, which is captured together with sum.

// 2-bit ripple full-adder slice used by the serial datapath.
module _FULL_ADDER_2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       c_in,
  output logic [1:0] s,
  output logic       c_out
);
  logic c_mid;

  // Two chained single-bit full adders
  always_comb begin
    s[0]  = a[0] ^ b[0] ^ c_in;
    c_mid = (a[0] & b[0]) | (c_in & (a[0] ^ b[0]));
    s[1]  = a[1] ^ b[1] ^ c_mid;
    c_out = (a[1] & b[1]) | (c_mid & (a[1] ^ b[1]));
  end
endmodule

module serial_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(HALF - 1);

  // The slice consumes two bits per cycle, so the width must split evenly.
  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_check
      $error("serial_add_seq: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             accept, last;
  logic [WIDTH-1:0] opa_reg, opb_reg, acc_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;

  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH+1:0] acc_cat;
  logic [WIDTH-1:0] acc_shift;

  _FULL_ADDER_2b u_slice (
    .a     (opa_reg[1:0]),
    .b     (opb_reg[1:0]),
    .c_in  (carry_reg),
    .s     (slice_sum),
    .c_out (slice_cout)
  );

  // New slice sum enters from the MSB end; after HALF shifts the
  // accumulator holds the full result with slice 0 at the bottom.
  always_comb begin
    acc_cat   = {slice_sum, acc_reg};
    acc_shift = acc_cat[WIDTH+1:2];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and control decode; DONE accepts a start like IDLE
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count_reg == LAST_SLICE) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state_reg == IDLE) || (state_reg == DONE);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);

  // Operand capture, per-slice shifting and result commit on the final slice
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_reg   <= '0;
      opb_reg   <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
      opa_reg   <= a;
      opb_reg   <= sub ? ~b : b;
      acc_reg   <= '0;
      carry_reg <= sub;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      acc_reg   <= acc_shift;
      carry_reg <= slice_cout;
      opa_reg   <= opa_reg >> 2;
      opb_reg   <= opb_reg >> 2;
      count_reg <= count_reg + 1'b1;
      if (last) begin
        sum   <= acc_shift;
        c_out <= slice_cout;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb_reg, b_msb_reg;

  // Keep operand sign bits; overflow is judged when the final slice lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (last) begin
      ovf <= (a_msb_reg == b_msb_reg) && (acc_shift[WIDTH-1] != a_msb_reg);
    end
  end
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq (WIDTH=8): directed cases followed by random
// operations, checked against an integer-arithmetic reference model.
// The ovf checks are included when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_seq;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready, busy, done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  // last committed result and the result of the operation in flight
  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;
  logic [W-1:0] pend_sum;
  logic         pend_cout, pend_ovf;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int r, sr;
    r  = s ? (int'(x) - int'(y)) : (int'(x) + int'(y));
    sr = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    pend_sum  = W'(r);
    pend_cout = s ? (x >= y) : (r > 255);
    pend_ovf  = (sr > 127) || (sr < -128);
  endtask

  task automatic chk_outputs(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) chk({tag, "_ovf_model"}, 32'(eo), 32'(0));
`endif
  endtask

  // Present an operation for one edge, then scramble the inputs.
  task automatic start_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    chk({tag, "_ready_before"}, 32'(ready), 32'(1));
    a = x; b = y; sub = s; start = 1'b1;
    model(x, y, s);
    tick;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  // Wait (bounded) for done; RUN cycles already observed are passed in.
  task automatic wait_done(input string tag, input int already);
    int n;
    n = already;
    while (done !== 1'b1 && n < 20) begin
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      chk({tag, "_ready_low"}, 32'(ready), 32'(0));
      chk({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
      tick;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W / 2));
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_ready_done"}, 32'(ready), 32'(1));
    chk_outputs(tag, pend_sum, pend_cout, pend_ovf);
    exp_sum  = pend_sum;
    exp_cout = pend_cout;
    exp_ovf  = pend_ovf;
  endtask

  // One cycle with start low: done must drop, result must hold.
  task automatic idle_step(input string tag);
    start = 1'b0;
    tick;
    chk({tag, "_done_drop"}, 32'(done), 32'(0));
    chk({tag, "_ready_idle"}, 32'(ready), 32'(1));
    chk({tag, "_busy_idle"}, 32'(busy), 32'(0));
    chk_outputs({tag, "_hold"}, exp_sum, exp_cout, exp_ovf);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'(1));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk_outputs(tag, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset, with start asserted to show reset wins
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34;
    tick;
    tick;
    chk_reset("reset");
    start = 1'b0;
    rst_n = 1'b1;
    tick;
    chk_reset("after_reset");

    // FF + 01: wraps to 00 with carry out
    start_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    wait_done("add_ff_01", 0);
    idle_step("add_ff_01");

    // 05 - 07: borrow
    start_op("sub_05_07", 8'h05, 8'h07, 1'b1);
    wait_done("sub_05_07", 0);
    idle_step("sub_05_07");

    // 7F + 01: signed overflow
    start_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
    wait_done("add_7f_01", 0);

    // back-to-back: start held during the DONE cycle
    start_op("b2b_10_20", 8'h10, 8'h20, 1'b0);
    wait_done("b2b_10_20", 0);
    idle_step("b2b_10_20");

    // start pulsed with new operands during RUN cycle 2 must be ignored
    start_op("ignore", 8'h3C, 8'h5A, 1'b0);
    tick;
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done("ignore", 2);
    idle_step("ignore");

    // reset during RUN cycle 3 aborts with no done pulse
    start_op("abort", 8'h33, 8'h44, 1'b0);
    tick;
    tick;
    chk("abort_busy_c3", 32'(busy), 32'(1));
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    chk_reset("abort");
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort_no_done", 32'(done), 32'(0));
    end
    start_op("post_abort", 8'h81, 8'h80, 1'b1);
    wait_done("post_abort", 0);
    idle_step("post_abort");

    // random operations, sometimes back-to-back
    for (int i = 0; i < 40; i++) begin
      start_op("rand", W'($urandom), W'($urandom), 1'($urandom));
      wait_done("rand", 0);
      if ($urandom_range(0, 1) == 1) idle_step("rand");
    end
    idle_step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
